// File: rtl/serial_link_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that feeds one byte at a time to a single-line serial
// transmitter and blocks new grants until the 9-bit frame has left the line.
module serial_link_arbiter #(
  parameter int N   = 4,
  parameter int GAP = 0,
  parameter int IW  = $clog2(N)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [N-1:0]   Req,
  input  logic [8*N-1:0] Data,
  output logic [N-1:0]   Ack,
  output logic [N-1:0]   Done,
  output logic           Send,
  output logic [7:0]     TxData,
  output logic [IW-1:0]  GrantId,
  output logic           Busy
);

  localparam logic [2:0] S_RECOVER = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_FRAME   = 3'd3;
  localparam logic [2:0] S_GAPW    = 3'd4;

  localparam logic [3:0] RECOVER_LAST = 4'd8;
  localparam logic [3:0] FRAME_LAST   = 4'd7;
  localparam logic [3:0] GAP_LAST     = 4'(GAP - 1);

  logic [2:0]    r_state;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_ptr;
  logic          r_send;
  logic [7:0]    r_txData;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_done;
  logic [IW-1:0] r_gid;

  logic [IW-1:0] w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_any;
  logic [IW-1:0] w_nextPtr;

  // First requester at or after the pointer, searching upward with wrap.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % N);
      if (!w_any && Req[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_nextPtr = (w_gnt == IW'(N - 1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_RECOVER;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_send   <= 1'b0;
      r_txData <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_gid    <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        // The transmitter is not reset, so wait out any frame it may still hold.
        S_RECOVER: begin
          if (r_cnt == RECOVER_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_any) begin
            r_gid        <= w_gnt;
            r_txData     <= Data[{w_gnt, 3'b000} +: 8];
            r_send       <= 1'b1;
            r_ack[w_gnt] <= 1'b1;
            r_ptr        <= w_nextPtr;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_send  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_FRAME;
        end
        S_FRAME: begin
          if (r_cnt == FRAME_LAST) begin
            r_done[r_gid] <= 1'b1;
            r_cnt         <= '0;
            r_state       <= (GAP > 0) ? S_GAPW : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAPW: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_RECOVER;
          r_cnt   <= '0;
          r_send  <= 1'b0;
        end
      endcase
    end
  end

  assign Ack     = r_ack;
  assign Done    = r_done;
  assign Send    = r_send;
  assign TxData  = r_txData;
  assign GrantId = r_gid;
  assign Busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_link_arbiter.sv
`timescale 1ns/1ps
// Directed bench for serial_link_arbiter: a GAP=0 instance with a transmitter and
// receiver model, plus a GAP=3 instance for frame spacing.
module tb_serial_link_arbiter;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          gid;
    logic [7:0]  tx;
    int          sp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [3:0]  Req0, Req1;
  logic [31:0] Data0, Data1;
  logic [3:0]  Ack0, Ack1, Done0, Done1;
  logic        Send0, Send1, Busy0, Busy1;
  logic [7:0]  TxData0, TxData1;
  logic [1:0]  GrantId0, GrantId1;

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  int lastGrant = 0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  vec_t vecs[9];

  serial_link_arbiter #(.N(4), .GAP(0)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req0), .Data(Data0), .Ack(Ack0), .Done(Done0),
    .Send(Send0), .TxData(TxData0), .GrantId(GrantId0), .Busy(Busy0)
  );

  serial_link_arbiter #(.N(4), .GAP(3)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req1), .Data(Data1), .Ack(Ack1), .Done(Done1),
    .Send(Send1), .TxData(TxData1), .GrantId(GrantId1), .Busy(Busy1)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Unreset transmitter models: load {start, byte} on Send, shift out MSB first.
  logic [8:0] txSh0 = '0, txSh1 = '0;
  int txBits0 = 0, txBits1 = 0;
  logic line0, line1;

  always @(posedge Clk) begin
    if (Send0 === 1'b1) begin
      txSh0   <= {1'b1, TxData0};
      txBits0 <= 9;
    end else if (txBits0 > 0) begin
      txSh0   <= txSh0 << 1;
      txBits0 <= txBits0 - 1;
    end
  end

  always @(posedge Clk) begin
    if (Send1 === 1'b1) begin
      txSh1   <= {1'b1, TxData1};
      txBits1 <= 9;
    end else if (txBits1 > 0) begin
      txSh1   <= txSh1 << 1;
      txBits1 <= txBits1 - 1;
    end
  end

  assign line0 = (txBits0 > 0) ? txSh0[8] : 1'b0;
  assign line1 = (txBits1 > 0) ? txSh1[8] : 1'b0;

  // Unreset receiver model on the GAP=0 line: start bit, then 8 data bits.
  logic       rxAct = 1'b0;
  logic [2:0] rxCnt = '0;
  logic [6:0] rxSh = '0;

  always @(posedge Clk) begin
    if (!rxAct) begin
      if (line0 === 1'b1) begin
        rxAct <= 1'b1;
        rxCnt <= '0;
      end
    end else begin
      rxSh  <= {rxSh[5:0], line0};
      rxCnt <= rxCnt + 1'b1;
      if (rxCnt == 3'd7) begin
        rxAct <= 1'b0;
        rxQ.push_back({rxSh, line0});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data, input int sel);
    @(negedge Clk);
    if (sel == 0) begin
      Req0  = req;
      Data0 = data;
    end else begin
      Req1  = req;
      Data1 = data;
    end
  endtask

  task automatic waitGrant(input int sel, input int limit, output int edges);
    logic [3:0] a;
    bit found;
    edges = 0;
    found = 0;
    while (!found && edges < limit) begin
      @(posedge Clk);
      #1;
      edges++;
      a = (sel == 0) ? Ack0 : Ack1;
      if (a != 4'b0000) found = 1;
    end
    if (!found) begin
      nCmp++;
      nErr++;
      $display("[TB] FAIL grant timeout dut%0d: no Ack in %0d edges, required one", sel, limit);
    end
  endtask

  task automatic checkOutput(input string name, input int expGid, input logic [7:0] expTx,
                             input int expSp);
    int e;
    waitGrant(0, 40, e);
    check($sformatf("%s ack", name), Ack0, 32'(1) << expGid);
    check($sformatf("%s send", name), Send0, 1);
    check($sformatf("%s txdata", name), TxData0, expTx);
    check($sformatf("%s grantid", name), GrantId0, expGid);
    if (expSp != 0) check($sformatf("%s spacing", name), cyc - lastGrant, expSp);
    lastGrant = cyc;
    expQ.push_back(expTx);
  endtask

  task automatic followFrame(input string name, input int expGid, input logic [7:0] expTx);
    logic [8:0] seen;
    seen = '0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge Clk);
      #1;
      seen = {seen[7:0], line0};
      if (e == 1) begin
        check($sformatf("%s send drop", name), Send0, 0);
        check($sformatf("%s ack drop", name), Ack0, 0);
        check($sformatf("%s busy", name), Busy0, 1);
      end
      if (e == 8) check($sformatf("%s done early", name), Done0, 0);
    end
    check($sformatf("%s done", name), Done0, 32'(1) << expGid);
    check($sformatf("%s line bits", name), seen, {1'b1, expTx});
  endtask

  initial begin
    int e;
    int nAck;
    int ackEdge[2];
    logic [3:0] ackVal[2];
    logic [7:0] ackTx[2];
    logic [13:0] gapLine;

    vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5, 0};
    vecs[1] = '{4'b1000, 32'h3C00_0000, 3, 8'h3C, 10};
    vecs[2] = '{4'b1111, 32'h4433_2211, 0, 8'h11, 10};
    vecs[3] = '{4'b1111, 32'h4433_2211, 1, 8'h22, 10};
    vecs[4] = '{4'b1111, 32'h4433_2211, 2, 8'h33, 10};
    vecs[5] = '{4'b1111, 32'h4433_2211, 3, 8'h44, 10};
    vecs[6] = '{4'b1111, 32'h4433_2211, 0, 8'h11, 10};
    vecs[7] = '{4'b0001, 32'h0000_0000, 0, 8'h00, 10};
    vecs[8] = '{4'b0001, 32'h0000_00FF, 0, 8'hFF, 10};

    Rst_n = 1'b0;
    Req0 = '0; Data0 = '0; Req1 = '0; Data1 = '0;
    repeat (3) @(negedge Clk);
    check("reset busy", Busy0, 1);
    check("reset send", Send0, 0);
    check("reset ack", Ack0, 0);
    check("reset done", Done0, 0);
    Rst_n = 1'b1;

    // Start a frame, then pull reset in the middle of it.
    applyStimulus(4'b0100, 32'h005A_0000, 0);
    waitGrant(0, 20, e);
    check("pre-reset grantid", GrantId0, 2);
    check("pre-reset txdata", TxData0, 8'h5A);
    expQ.push_back(8'h5A);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    Req0  = 4'b0001;
    Data0 = 32'h0000_00C3;
    #1;
    check("midreset send", Send0, 0);
    check("midreset busy", Busy0, 1);
    check("midreset ack", Ack0, 0);
    check("midreset txdata", TxData0, 0);
    check("midreset grantid", GrantId0, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    waitGrant(0, 15, e);
    check("flush grant edge", e, 10);
    check("flush ack", Ack0, 4'b0001);
    check("flush txdata", TxData0, 8'hC3);
    lastGrant = cyc;
    expQ.push_back(8'hC3);

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].req, vecs[k].data, 0);
      checkOutput($sformatf("vec%0d", k), vecs[k].gid, vecs[k].tx, vecs[k].sp);
      followFrame($sformatf("vec%0d", k), vecs[k].gid, vecs[k].tx);
    end

    // Requester 1 withdraws and requester 3 arrives while a frame is on the line.
    applyStimulus(4'b0011, 32'hB300_B1B0, 0);
    checkOutput("wd first", 1, 8'hB1, 10);
    repeat (4) @(negedge Clk);
    Req0 = 4'b1001;
    checkOutput("wd late", 3, 8'hB3, 10);
    checkOutput("wd wrap", 0, 8'hB0, 10);
    applyStimulus(4'b0000, 32'h0, 0);
    repeat (12) @(negedge Clk);
    check("idle busy", Busy0, 0);
    check("idle ack", Ack0, 0);

    check("rx count", rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rxQ.size()) check($sformatf("rx byte %0d", i), rxQ[i], expQ[i]);
    end

    // GAP=3 instance: 13-cycle grant spacing and 4 idle-low line cycles.
    applyStimulus(4'b0011, 32'h0000_7E81, 1);
    waitGrant(1, 20, e);
    check("gap first ack", Ack1, 4'b0001);
    check("gap first txdata", TxData1, 8'h81);
    nAck = 0;
    ackEdge[0] = 0; ackEdge[1] = 0;
    ackVal[0] = '0; ackVal[1] = '0;
    ackTx[0] = '0; ackTx[1] = '0;
    gapLine = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge Clk);
      #1;
      if (k <= 14) gapLine = {gapLine[12:0], line1};
      if (Ack1 != 4'b0000 && nAck < 2) begin
        ackEdge[nAck] = k;
        ackVal[nAck]  = Ack1;
        ackTx[nAck]   = TxData1;
        nAck++;
      end
    end
    Req1 = 4'b0000;
    check("gap grant2 edge", ackEdge[0], 13);
    check("gap grant2 ack", ackVal[0], 4'b0010);
    check("gap grant2 txdata", ackTx[0], 8'h7E);
    check("gap grant3 edge", ackEdge[1], 26);
    check("gap grant3 ack", ackVal[1], 4'b0001);
    check("gap line", gapLine, {1'b1, 8'h81, 4'b0000, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at 100000 ns, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_link_arbiter.md
# serial_link_arbiter

Round-robin controller that shares the single-line serial transmitter among N byte-producing requesters. It accepts one byte at a time from whichever requester wins arbitration and drives the transmitter's `Send`/`PDin` inputs. It then holds off further grants until the 9-bit frame (start bit plus 8 data bits, MSB first) has fully left the line, so the downstream serial receiver never sees overlapping frames. It sits between the requester logic and the transmitter, in the transmitter's `Clk` domain.

## Interface
- `N`, 4: number of requesters; 2..8.
- `GAP`, 0: extra idle link cycles inserted after each frame; 0..15.
- `IW`, `$clog2(N)`: grant index width (derived; do not override).

- `Clk`  in  1  system clock, rising edge; same clock as the transmitter.
- `Rst_n`  in  1  asynchronous active-low reset.
- `Req`  in  N  per-requester level request; bit i is held with `Data` byte i until `Ack[i]`.
- `Data`  in  8*N  byte i is on bits [8i+7:8i].
- `Ack`  out  N  one-cycle pulse: byte i has been captured.
- `Done`  out  N  one-cycle pulse: the last data bit of requester i's frame is on the line.
- `Send`  out  1  to transmitter `Send`; registered, one-cycle pulse.
- `TxData`  out  8  to transmitter `PDin`; registered, held stable from grant to next grant.
- `GrantId`  out  IW  index of the current or last granted requester.
- `Busy`  out  1  high in every state except IDLE.

## Operation
- States: RECOVER, IDLE, LOAD, FRAME, GAPW. A 4-bit counter `cnt` is shared by all states that count.
- **RECOVER** (reset state): flushes any frame left in the unreset transmitter. Stays 9 cycles (`cnt` 0..8), then goes to IDLE.
- **IDLE**: if `Req` is non-zero at an edge, perform the grant on that edge:
  - choose the first set bit at or after `ptr`, searching upward with wrap;
  - load `GrantId`=g and `TxData`=`Data[g]`;
  - assert `Send`=1 and `Ack[g]`=1 for one cycle;
  - set `ptr`=(g+1) mod N;
  - go to LOAD.
- **LOAD**: lasts one cycle, during which `Send` is high. On the next edge the transmitter loads; the arbiter clears `Send`, sets `cnt`=0 and goes to FRAME.
- **FRAME**: counts 8 edges. On the edge where `cnt`==7:
  - pulse `Done[GrantId]`;
  - go to GAPW if `GAP`>0, otherwise to IDLE.
- **GAPW**: stays `GAP` cycles, then goes to IDLE.
- Requests are sampled only in IDLE. `Req` changes in any other state are ignored.
- A requester that drops `Req` before its `Ack` withdraws its request; no capture occurs.
- A requester that keeps `Req` high after its `Ack` is requesting another frame. It is re-granted only in round-robin turn.
- `ptr` advances only on a grant.
- Reset values: state=RECOVER, `cnt`=0, `ptr`=0, `Send`=0, `TxData`=0, `Ack`=0, `Done`=0, `GrantId`=0, `Busy`=1.
- Reset asserted mid-frame: all outputs return to their reset values immediately. After `Rst_n` rises, RECOVER runs its full 9 cycles before any grant.

## Timing
- Grant at edge A:
  - `Ack`, `Send` and `TxData` are valid in cycle A..A+1.
  - The transmitter loads at A+1; the start bit is on the line after A+1.
  - Data bits d7..d0 are on the line after A+2..A+9.
  - `Done` is high in cycle A+9..A+10.
  - The receiver's `PDready` rises after A+10.
- Earliest next grant is at A+9+GAP+1, giving a minimum frame period of 10+GAP cycles.
- Once state leaves IDLE, the line is idle-low for at least 1+GAP cycles between consecutive frames.
- First grant after reset release: the earliest grant edge is the 10th rising edge after `Rst_n` rises.

## Test plan
- **Reset flush.** Preload the transmitter with a frame, assert `Rst_n`=0 mid-frame, then release with `Req`=4'b0001.
  - While in reset: `Send`=0, `Busy`=1.
  - After release: no `Ack` before the 10th edge; the grant occurs on the 10th edge.
- **Single byte.** `Req`[2]=1, `Data` byte 2=8'hA5, `GAP`=0.
  - `Ack`=4'b0100 and `Send`=1 for one cycle; `TxData`=8'hA5; `GrantId`=2.
  - Line carries 1,1,0,1,0,0,1,0,1.
  - `Done`[2] pulses 9 cycles after the grant; the receiver outputs `PDout`=8'hA5.
- **All requesting.** Hold `Req`=4'b1111 with distinct bytes 8'h11, 8'h22, 8'h33, 8'h44.
  - Grant order is 0,1,2,3,0.
  - Grant edges are spaced exactly 10 cycles apart.
  - The receiver outputs the bytes in grant order.
- **Withdrawal and late arrival.** Drop `Req`[1] during FRAME, and raise `Req`[3] during FRAME.
  - No `Ack`[1] is issued.
  - `Ack`[3] is issued on the first IDLE edge.
  - `ptr` wraps correctly after the grant to 3.
- **Gap.** With `GAP`=3 and `Req`=4'b0011 held, consecutive grants are 13 cycles apart and the line stays low for 4 cycles between frames.
- **Edge data.** `Data`=8'h00 and then 8'hFF back-to-back.
  - The receiver outputs 8'h00 then 8'hFF.
  - For 8'h00, no spurious second frame is detected.
